// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-sequencer bundle: hazard/branch/imem inputs toward the sequencer, PC and fetch status back out.
// The slave modport is the sequencer side; the master modport drives stimulus and observes.
interface pc_fetch_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             stall;
    logic             br_taken;
    logic [63:0]      br_target;
    logic             imem_ready;
    logic [63:0]      pc;
    logic [63:0]      pc_plus4;
    logic             fetch_valid;
    logic             flush_if;
    logic             redirect_pending;
    logic             misalign;
    logic [CNT_W-1:0] fetch_count;

    modport slave (
        input  stall, br_taken, br_target, imem_ready,
        output pc, pc_plus4, fetch_valid, flush_if, redirect_pending, misalign, fetch_count
    );

    modport master (
        output stall, br_taken, br_target, imem_ready,
        input  pc, pc_plus4, fetch_valid, flush_if, redirect_pending, misalign, fetch_count
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner: picks PC+4, branch redirect, stall hold or imem back-pressure each cycle.
// Redirect reaches pc one cycle after it is applied; a redirect seen under stall waits in HOLD until release.
module pc_fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    pc_fetch_sequencer_if.slave   fetch_bus
);
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           r_state;
    logic [63:0]      r_pc;
    logic [63:0]      r_pend_tgt;
    logic             r_pend_mis;
    logic             r_pend_vld;
    logic [CNT_W-1:0] r_fetch_cnt;

    state_t           w_nxt_state;
    logic [63:0]      w_nxt_pc;
    logic [63:0]      w_pc_plus4;
    logic [63:0]      w_br_aligned;
    logic             w_br_mis;
    logic             w_fetch_vld;
    logic             w_flush;
    logic             w_mis;
    logic             w_latch;

    assign w_pc_plus4   = r_pc + 64'd4;
    assign w_br_aligned = {fetch_bus.br_target[63:2], 2'b00};
    assign w_br_mis     = |fetch_bus.br_target[1:0];

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_pc    = r_pc;
        w_fetch_vld = 1'b0;
        w_flush     = 1'b0;
        w_mis       = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            BOOT: begin
                w_nxt_state = RUN;
            end
            RUN: begin
                if (fetch_bus.br_taken && !fetch_bus.stall) begin
                    w_nxt_pc = w_br_aligned;
                    w_flush  = 1'b1;
                    w_mis    = w_br_mis;
                end else if (fetch_bus.br_taken) begin
                    w_latch     = 1'b1;
                    w_nxt_state = HOLD;
                end else if (!fetch_bus.stall) begin
                    w_fetch_vld = fetch_bus.imem_ready;
                    if (fetch_bus.imem_ready) begin
                        w_nxt_pc = w_pc_plus4;
                    end
                end
            end
            HOLD: begin
                // Younger branches during the stall are on the wrong path; only the buffered one applies.
                if (!fetch_bus.stall) begin
                    w_nxt_pc    = r_pend_tgt;
                    w_flush     = 1'b1;
                    w_mis       = r_pend_mis;
                    w_nxt_state = RUN;
                end
            end
            default: begin
                w_nxt_state = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= BOOT;
            r_pc        <= RESET_PC;
            r_pend_tgt  <= 64'd0;
            r_pend_mis  <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_fetch_cnt <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_pc    <= w_nxt_pc;
            if (w_latch) begin
                r_pend_tgt <= w_br_aligned;
                r_pend_mis <= w_br_mis;
                r_pend_vld <= 1'b1;
            end else if (w_nxt_state != HOLD) begin
                r_pend_vld <= 1'b0;
            end
            if (w_fetch_vld && (r_fetch_cnt != {CNT_W{1'b1}})) begin
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
            end
        end
    end

    assign fetch_bus.pc               = r_pc;
    assign fetch_bus.pc_plus4         = w_pc_plus4;
    assign fetch_bus.fetch_valid      = w_fetch_vld;
    assign fetch_bus.flush_if         = w_flush;
    assign fetch_bus.redirect_pending = r_pend_vld;
    assign fetch_bus.misalign         = w_mis;
    assign fetch_bus.fetch_count      = r_fetch_cnt;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed-vector scoreboard bench: each stimulus cycle queues its expected outputs, a negedge monitor pops and compares.
module tb_pc_fetch_sequencer;
    logic clk;
    logic reset;

    pc_fetch_sequencer_if #(.CNT_W(32)) bif ();
    pc_fetch_sequencer_if #(.CNT_W(2))  sif ();

    pc_fetch_sequencer #(.RESET_PC(64'd0), .CNT_W(32)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .fetch_bus (bif.slave)
    );

    pc_fetch_sequencer #(.RESET_PC(64'd0), .CNT_W(2)) u_sat (
        .clk       (clk),
        .reset     (reset),
        .fetch_bus (sif.slave)
    );

    assign sif.stall      = bif.stall;
    assign sif.br_taken   = bif.br_taken;
    assign sif.br_target  = bif.br_target;
    assign sif.imem_ready = bif.imem_ready;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] pc4;
        logic        fv;
        logic        fl;
        logic        rp;
        logic        mis;
        logic [31:0] cnt;
        logic [1:0]  sat;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic st, input logic br, input logic [63:0] tgt,
                        input logic rdy, input logic [63:0] e_pc, input logic e_fv, input logic e_fl,
                        input logic e_rp, input logic e_mis, input logic [31:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        reset          = rst;
        bif.stall      = st;
        bif.br_taken   = br;
        bif.br_target  = tgt;
        bif.imem_ready = rdy;
        e.pc  = e_pc;
        e.pc4 = e_pc + 64'd4;
        e.fv  = e_fv;
        e.fl  = e_fl;
        e.rp  = e_rp;
        e.mis = e_mis;
        e.cnt = e_cnt;
        e.sat = (e_cnt > 32'd3) ? 2'd3 : e_cnt[1:0];
        exp_q.push_back(e);
        cyc++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = exp_q.pop_front();
            a.pc  = bif.pc;
            a.pc4 = bif.pc_plus4;
            a.fv  = bif.fetch_valid;
            a.fl  = bif.flush_if;
            a.rp  = bif.redirect_pending;
            a.mis = bif.misalign;
            a.cnt = bif.fetch_count;
            a.sat = sif.fetch_count;
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL cyc%0d got pc=%h p4=%h fv=%b fl=%b rp=%b mis=%b cnt=%0d sat=%0d want pc=%h p4=%h fv=%b fl=%b rp=%b mis=%b cnt=%0d sat=%0d",
                         cyc, a.pc, a.pc4, a.fv, a.fl, a.rp, a.mis, a.cnt, a.sat,
                         e.pc, e.pc4, e.fv, e.fl, e.rp, e.mis, e.cnt, e.sat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        reset          = 1'b1;
        bif.stall      = 1'b0;
        bif.br_taken   = 1'b0;
        bif.br_target  = 64'd0;
        bif.imem_ready = 1'b1;
        //   rst st br target                  rdy  pc                       fv fl rp mis cnt
        step(1, 0, 0, 64'd0,                  1,   64'h0,                   0, 0, 0, 0, 0);
        step(0, 0, 0, 64'd0,                  1,   64'h0,                   0, 0, 0, 0, 0);
        step(0, 0, 0, 64'd0,                  1,   64'h0,                   1, 0, 0, 0, 0);
        step(0, 0, 0, 64'd0,                  1,   64'h4,                   1, 0, 0, 0, 1);
        step(0, 0, 0, 64'd0,                  1,   64'h8,                   1, 0, 0, 0, 2);
        step(0, 0, 0, 64'd0,                  1,   64'hC,                   1, 0, 0, 0, 3);
        step(0, 0, 1, 64'h100,                1,   64'h10,                  0, 1, 0, 0, 4);
        step(0, 0, 0, 64'd0,                  1,   64'h100,                 1, 0, 0, 0, 4);
        // stalled redirect to 0x200, younger 0x300 must be dropped
        step(0, 1, 1, 64'h200,                1,   64'h104,                 0, 0, 0, 0, 5);
        step(0, 1, 1, 64'h300,                1,   64'h104,                 0, 0, 1, 0, 5);
        step(0, 1, 0, 64'd0,                  1,   64'h104,                 0, 0, 1, 0, 5);
        step(0, 0, 0, 64'd0,                  1,   64'h104,                 0, 1, 1, 0, 5);
        step(0, 0, 0, 64'd0,                  1,   64'h200,                 1, 0, 0, 0, 5);
        step(0, 0, 1, 64'h103,                1,   64'h204,                 0, 1, 0, 1, 6);
        step(0, 0, 0, 64'd0,                  1,   64'h100,                 1, 0, 0, 0, 6);
        step(0, 0, 1, 64'h40,                 1,   64'h104,                 0, 1, 0, 0, 7);
        step(0, 0, 0, 64'd0,                  0,   64'h40,                  0, 0, 0, 0, 7);
        step(0, 0, 0, 64'd0,                  0,   64'h40,                  0, 0, 0, 0, 7);
        step(0, 0, 0, 64'd0,                  1,   64'h40,                  1, 0, 0, 0, 7);
        step(0, 0, 0, 64'd0,                  1,   64'h44,                  1, 0, 0, 0, 8);
        // misaligned target buffered through HOLD
        step(0, 1, 1, 64'h601,                1,   64'h48,                  0, 0, 0, 0, 9);
        step(0, 0, 0, 64'd0,                  1,   64'h48,                  0, 1, 1, 1, 9);
        step(0, 0, 0, 64'd0,                  1,   64'h600,                 1, 0, 0, 0, 9);
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1,  64'h604,                 0, 1, 0, 0, 10);
        step(0, 0, 0, 64'd0,                  1,   64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 0, 10);
        step(0, 0, 0, 64'd0,                  1,   64'h0,                   1, 0, 0, 0, 11);
        step(0, 1, 0, 64'd0,                  1,   64'h4,                   0, 0, 0, 0, 12);
        step(0, 0, 0, 64'd0,                  1,   64'h4,                   1, 0, 0, 0, 12);
        // reset while holding 0x500: target must never reach pc
        step(0, 1, 1, 64'h500,                1,   64'h8,                   0, 0, 0, 0, 13);
        step(0, 1, 0, 64'd0,                  1,   64'h8,                   0, 0, 1, 0, 13);
        step(1, 0, 0, 64'd0,                  1,   64'h0,                   0, 0, 0, 0, 0);
        step(0, 0, 1, 64'h500,                1,   64'h0,                   0, 0, 0, 0, 0);
        step(0, 0, 0, 64'd0,                  1,   64'h0,                   1, 0, 0, 0, 0);
        step(0, 0, 0, 64'd0,                  1,   64'h4,                   1, 0, 0, 0, 1);
        step(0, 0, 0, 64'd0,                  1,   64'h8,                   1, 0, 0, 0, 2);
        step(0, 0, 0, 64'd0,                  1,   64'hC,                   1, 0, 0, 0, 3);
        step(0, 0, 0, 64'd0,                  1,   64'h10,                  1, 0, 0, 0, 4);
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
